dll_lock_sequencer: RTL and testbench
=====================================

# dll_lock_sequencer

Lock-acquisition and tracking sequencer for the FMDLL phase tracking controller (PTC). It holds the PTC in reset and releases it, waits for the harmonic lock detector to release the phase detector, times the 10-bit SAR binary search, and then monitors PD comparator activity in lock. On loss of lock it re-runs acquisition with bounded retries. It sits between the top-level configuration and the PTC, driving the PTC's reset, divider enables and M/N configuration.

## Interface
Parameters:
- SAR_BITS, 10, SAR resolution (steps per search)
- STEP_DIV, 4, clk_ext cycles per SAR step (matches the clk4 rate)
- RST_CYC, 4, PTC reset pulse length in cycles
- HLD_TIMEOUT, 1024, max cycles to wait for PD release
- SETTLE_CYC, 16, cycles after the last SAR step before declaring lock
- TRACK_LIMIT, 8, consecutive identical comp samples that flag loss of lock
- MAX_RETRY, 3, consecutive HLD timeouts before fault

Ports:
- clk_ext  in  1  system/reference clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  level; 1 = run acquisition/tracking, 0 = park in IDLE
- cfg_m  in  2  M divide select, captured on leaving IDLE
- cfg_n  in  4  N multiply select, captured on leaving IDLE
- hld_reset_pd  in  1  PD reset from the harmonic lock detector (1 = PD held)
- comp  in  1  PD comparator output
- sar_q  in  10  current SAR code
- ptc_rst  out  1  active-high reset to the PTC (inverted externally to rst_n)
- div_m, div_n  out  1  divider enables to the PTC
- m_out  out  2  latched cfg_m
- n_out  out  4  latched cfg_n
- locked  out  1  lock indication
- fault  out  1  sticky acquisition failure
- state  out  3  FSM state encoding
- lock_code  out  10  SAR code captured at lock
- relock_count  out  8  saturating count of loss-of-lock events

## Operation
- States: IDLE(0), PRST(1), HLD_WAIT(2), SAR_RUN(3), SETTLE(4), LOCKED(5), FAULT(6).
- IDLE: ptc_rst=1, div_m=div_n=0. When enable=1, latch cfg_m/cfg_n, clear the retry counter and go to PRST.
- PRST: ptc_rst=1 for RST_CYC cycles, then go to HLD_WAIT. div_m=1 and div_n=(n_out!=0) from PRST through LOCKED.
- HLD_WAIT: ptc_rst=0. Go to SAR_RUN when hld_reset_pd=0 is sampled on 2 consecutive cycles.
  - On HLD_TIMEOUT cycles without release, increment retry. If retry then equals MAX_RETRY, go to FAULT; otherwise go to PRST.
- SAR_RUN: last exactly SAR_BITS*STEP_DIV cycles (40 by default), then go to SETTLE. On the exit cycle, capture sar_q into lock_code.
- SETTLE: SETTLE_CYC cycles, then go to LOCKED and clear retry.
- LOCKED: locked=1.
  - Sample comp every STEP_DIV cycles (phase counter restarts on entry).
  - Track the run length of identical consecutive samples. Reaching TRACK_LIMIT triggers loss of lock: locked=0, relock_count+1 saturating at 255, go to PRST.
- FAULT: fault=1, ptc_rst=1, div enables 0. Stay in FAULT until enable=0, then go to IDLE with fault cleared.
- enable=0 in any state except FAULT: go to IDLE on the next edge. locked drops on that same edge.

## Timing
- Reset values: state=IDLE, ptc_rst=1, div_m=div_n=0, m_out=0, n_out=0, locked=0, fault=0, lock_code=0, relock_count=0. All counters are 0.
- All outputs are registered; state changes are visible one cycle after the qualifying input.
- Minimum enable-to-locked latency: 1 + RST_CYC + 2 + SAR_BITS*STEP_DIV + SETTLE_CYC = 63 cycles with default parameters and hld_reset_pd already low.
- Simultaneous events:
  - enable=0 wins over every other transition.
  - A loss-of-lock condition on the cycle enable falls goes to IDLE; relock_count is still incremented.
- Asserting rst mid-operation returns every output to its reset value immediately, asynchronously.
- cfg_m/cfg_n changes after IDLE are ignored until the next pass through IDLE.

## Structure
- Shared package holds the state encoding constants (IDLE..FAULT), the default parameter values, and the SAR_BITS width constant shared with the SAR.
- One natural sub-module: dll_lock_monitor. It implements the LOCKED-state comp sampler and run-length detector and outputs a single loss_of_lock pulse.
- The FSM, timers and retry/relock counters live in the top module.

## Test plan
- Normal acquisition: enable=1, cfg_n=4, hld_reset_pd=0, comp toggling each sample, sar_q=10'h1A5 at the SAR exit -> locked=1 at cycle 63, lock_code=10'h1A5, div_n=1.
- HLD timeout: hld_reset_pd held 1 -> three PRST passes, then fault=1, state=6. Deasserting enable -> IDLE, fault=0.
- Loss of lock: in LOCKED, hold comp=1 -> locked=0 after 8 samples (32 cycles), relock_count=1, state returns to PRST. With comp toggling again, the block relocks.
- Abort: enable=0 mid SAR_RUN -> next cycle state=IDLE, ptc_rst=1, div_m=0. Re-enable latches the new cfg_m.
- Async reset in LOCKED: pulse rst for half a cycle -> all outputs reach reset values without a clock edge, and relock_count=0.

Source files
------------

// File: rtl/dll_lock_sequencer_pkg.sv
// Shared definitions for the FMDLL lock-acquisition sequencer.
// Holds the FSM state encoding, default timing parameters and the SAR code
// width shared with the phase tracking controller's SAR.
package dll_lock_sequencer_pkg;

  localparam int SAR_W           = 10;
  localparam int DEF_STEP_DIV    = 4;
  localparam int DEF_RST_CYC     = 4;
  localparam int DEF_HLD_TIMEOUT = 1024;
  localparam int DEF_SETTLE_CYC  = 16;
  localparam int DEF_TRACK_LIMIT = 8;
  localparam int DEF_MAX_RETRY   = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRST     = 3'd1,
    ST_HLD_WAIT = 3'd2,
    ST_SAR_RUN  = 3'd3,
    ST_SETTLE   = 3'd4,
    ST_LOCKED   = 3'd5,
    ST_FAULT    = 3'd6
  } state_e;

  // Increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dll_lock_monitor.sv
// In-lock comparator activity monitor.
// While active_i is high, samples comp_i once every STEP_DIV cycles (the
// phase counter restarts whenever active_i rises) and tracks the run length
// of identical consecutive samples. loss_of_lock_o is a combinational
// one-cycle pulse on the sample that makes the run reach TRACK_LIMIT.
// Ports:
//   clk_ext        in  clock
//   rst            in  asynchronous active-high reset
//   active_i       in  1 while the sequencer is in LOCKED
//   comp_i         in  PD comparator output
//   loss_of_lock_o out loss-of-lock pulse
module dll_lock_monitor #(
  parameter int STEP_DIV    = 4,
  parameter int TRACK_LIMIT = 8
) (
  input  logic clk_ext,
  input  logic rst,
  input  logic active_i,
  input  logic comp_i,
  output logic loss_of_lock_o
);

  localparam int PH_W  = $clog2(STEP_DIV + 1);
  localparam int RUN_W = $clog2(TRACK_LIMIT + 1);

  logic [PH_W-1:0]  ph_q;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;
  logic             prev_q;
  logic             sample;

  assign sample = active_i && (ph_q == PH_W'(STEP_DIV - 1));

  // A run of zero means no sample has been taken since entry.
  always_comb begin
    run_d = RUN_W'(1);
    if ((run_q != '0) && (comp_i == prev_q)) run_d = run_q + 1'b1;
  end

  assign loss_of_lock_o = sample && (run_d == RUN_W'(TRACK_LIMIT));

  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      ph_q   <= '0;
      run_q  <= '0;
      prev_q <= 1'b0;
    end else if (!active_i) begin
      ph_q   <= '0;
      run_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      ph_q <= sample ? '0 : ph_q + 1'b1;
      if (sample) begin
        prev_q <= comp_i;
        run_q  <= loss_of_lock_o ? '0 : run_d;
      end
    end
  end

endmodule

// File: rtl/dll_lock_sequencer.sv
// Lock-acquisition and tracking sequencer for the FMDLL phase tracking
// controller. Resets the PTC, waits for the harmonic lock detector to
// release the PD, times the SAR search and settle interval, then watches
// comparator activity while locked and re-acquires on loss of lock.
// Ports:
//   clk_ext, rst        clock, asynchronous active-high reset
//   enable              1 = acquire/track, 0 = park in IDLE
//   cfg_m, cfg_n        divider configuration, latched on leaving IDLE
//   hld_reset_pd        PD held in reset by the harmonic lock detector
//   comp, sar_q         PD comparator output, current SAR code
//   ptc_rst             PTC reset (active high)
//   div_m, div_n        PTC divider enables
//   m_out, n_out        latched configuration
//   locked, fault       lock indication, sticky acquisition failure
//   state               FSM state encoding
//   lock_code           SAR code captured at the end of the search
//   relock_count        saturating loss-of-lock event count
module dll_lock_sequencer
  import dll_lock_sequencer_pkg::*;
#(
  parameter int SAR_BITS    = SAR_W,
  parameter int STEP_DIV    = DEF_STEP_DIV,
  parameter int RST_CYC     = DEF_RST_CYC,
  parameter int HLD_TIMEOUT = DEF_HLD_TIMEOUT,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int TRACK_LIMIT = DEF_TRACK_LIMIT,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic                clk_ext,
  input  logic                rst,
  input  logic                enable,
  input  logic [1:0]          cfg_m,
  input  logic [3:0]          cfg_n,
  input  logic                hld_reset_pd,
  input  logic                comp,
  input  logic [SAR_BITS-1:0] sar_q,
  output logic                ptc_rst,
  output logic                div_m,
  output logic                div_n,
  output logic [1:0]          m_out,
  output logic [3:0]          n_out,
  output logic                locked,
  output logic                fault,
  output logic [2:0]          state,
  output logic [SAR_BITS-1:0] lock_code,
  output logic [7:0]          relock_count
);

  localparam int SAR_CYC = SAR_BITS * STEP_DIV;
  localparam int MAX_A   = (RST_CYC > HLD_TIMEOUT) ? RST_CYC : HLD_TIMEOUT;
  localparam int MAX_B   = (SAR_CYC > SETTLE_CYC) ? SAR_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(((MAX_A > MAX_B) ? MAX_A : MAX_B) + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  low_q, low_d;
  logic [RTY_W-1:0]      retry_q, retry_d;
  logic [1:0]            m_q, m_d;
  logic [3:0]            n_q, n_d;
  logic [SAR_BITS-1:0]   code_q, code_d;
  logic [7:0]            relock_q, relock_d;
  logic                  ptc_rst_q, div_m_q, div_n_q, locked_q, fault_q;
  logic                  loss_of_lock;
  logic                  run_path;

  dll_lock_monitor #(
    .STEP_DIV    (STEP_DIV),
    .TRACK_LIMIT (TRACK_LIMIT)
  ) u_monitor (
    .clk_ext        (clk_ext),
    .rst            (rst),
    .active_i       (state_q == ST_LOCKED),
    .comp_i         (comp),
    .loss_of_lock_o (loss_of_lock)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    low_d    = 1'b0;
    retry_d  = retry_q;
    m_d      = m_q;
    n_d      = n_q;
    code_d   = code_q;
    relock_d = loss_of_lock ? sat_inc8(relock_q) : relock_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_PRST;
          m_d     = cfg_m;
          n_d     = cfg_n;
          retry_d = '0;
        end
      end
      ST_PRST: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(RST_CYC - 1)) state_d = ST_HLD_WAIT;
      end
      ST_HLD_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // low_q remembers that the previous sample already saw the PD released.
        if (!hld_reset_pd) begin
          low_d = 1'b1;
          if (low_q) state_d = ST_SAR_RUN;
        end
        if ((state_d == ST_HLD_WAIT) && (cnt_q == CNT_W'(HLD_TIMEOUT - 1))) begin
          retry_d = retry_q + 1'b1;
          state_d = (retry_d == RTY_W'(MAX_RETRY)) ? ST_FAULT : ST_PRST;
        end
      end
      ST_SAR_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SAR_CYC - 1)) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          state_d = ST_LOCKED;
          retry_d = '0;
        end
      end
      ST_LOCKED: begin
        if (loss_of_lock) state_d = ST_PRST;
      end
      ST_FAULT: begin
        if (!enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Dropping enable overrides every other transition; FAULT only leaves this way.
    if (!enable && (state_q != ST_FAULT)) state_d = ST_IDLE;

    // The search result is only kept on a normal SAR exit.
    if ((state_q == ST_SAR_RUN) && (state_d == ST_SETTLE)) code_d = sar_q;

    if (state_d != state_q) begin
      cnt_d = '0;
      low_d = 1'b0;
    end
  end

  assign run_path = (state_d == ST_PRST) || (state_d == ST_HLD_WAIT) ||
                    (state_d == ST_SAR_RUN) || (state_d == ST_SETTLE) ||
                    (state_d == ST_LOCKED);

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      low_q     <= 1'b0;
      retry_q   <= '0;
      m_q       <= '0;
      n_q       <= '0;
      code_q    <= '0;
      relock_q  <= '0;
      ptc_rst_q <= 1'b1;
      div_m_q   <= 1'b0;
      div_n_q   <= 1'b0;
      locked_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      low_q     <= low_d;
      retry_q   <= retry_d;
      m_q       <= m_d;
      n_q       <= n_d;
      code_q    <= code_d;
      relock_q  <= relock_d;
      ptc_rst_q <= (state_d == ST_IDLE) || (state_d == ST_PRST) || (state_d == ST_FAULT);
      div_m_q   <= run_path;
      div_n_q   <= run_path && (n_d != 4'd0);
      locked_q  <= (state_d == ST_LOCKED);
      fault_q   <= (state_d == ST_FAULT);
    end
  end

  assign state        = state_q;
  assign ptc_rst      = ptc_rst_q;
  assign div_m        = div_m_q;
  assign div_n        = div_n_q;
  assign m_out        = m_q;
  assign n_out        = n_q;
  assign locked       = locked_q;
  assign fault        = fault_q;
  assign lock_code    = code_q;
  assign relock_count = relock_q;

endmodule

// File: tb/tb_dll_lock_sequencer.sv
module tb_dll_lock_sequencer;

  localparam int SAR_BITS    = 10;
  localparam int STEP_DIV    = 4;
  localparam int RST_CYC     = 4;
  localparam int HLD_TIMEOUT = 1024;
  localparam int SETTLE_CYC  = 16;
  localparam int TRACK_LIMIT = 8;
  localparam int MAX_RETRY   = 3;

  logic        clk_ext = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  cfg_m = 2'd0;
  logic [3:0]  cfg_n = 4'd0;
  logic        hld_reset_pd = 1'b0;
  logic        comp = 1'b0;
  logic [9:0]  sar_q = 10'h000;
  logic        ptc_rst, div_m, div_n, locked, fault;
  logic [1:0]  m_out;
  logic [3:0]  n_out;
  logic [2:0]  state;
  logic [9:0]  lock_code;
  logic [7:0]  relock_count;

  int tests = 0;
  int fails = 0;
  logic comp_hold = 1'b0;

  dll_lock_sequencer dut (
    .clk_ext      (clk_ext),
    .rst          (rst),
    .enable       (enable),
    .cfg_m        (cfg_m),
    .cfg_n        (cfg_n),
    .hld_reset_pd (hld_reset_pd),
    .comp         (comp),
    .sar_q        (sar_q),
    .ptc_rst      (ptc_rst),
    .div_m        (div_m),
    .div_n        (div_n),
    .m_out        (m_out),
    .n_out        (n_out),
    .locked       (locked),
    .fault        (fault),
    .state        (state),
    .lock_code    (lock_code),
    .relock_count (relock_count)
  );

  initial forever #5 clk_ext = ~clk_ext;

  // Comparator stimulus: value flips every STEP_DIV cycles, or held at 1.
  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk_ext);
      #1;
      cyc++;
      comp = comp_hold ? 1'b1 : ((cyc / STEP_DIV) % 2 == 1);
    end
  end

  // ---------------- behavioural model ----------------
  // Phases numbered by their visible state code; m_t = cycles spent in phase.
  int m_st = 0, m_t = 0, m_low = 0, m_retry = 0;
  int m_m = 0, m_n = 0, m_code = 0, m_relock = 0;
  int hist[$];

  task automatic model_step();
    int  nst;
    bit  loss;
    bit  same;
    if (rst) begin
      m_st = 0; m_t = 0; m_low = 0; m_retry = 0;
      m_m = 0; m_n = 0; m_code = 0; m_relock = 0;
      hist.delete();
      return;
    end
    nst  = m_st;
    loss = 0;
    case (m_st)
      0: if (enable) begin nst = 1; m_m = cfg_m; m_n = cfg_n; m_retry = 0; end
      1: if (m_t + 1 >= RST_CYC) nst = 2;
      2: begin
        m_low = hld_reset_pd ? 0 : m_low + 1;
        if (m_low >= 2) nst = 3;
        else if (m_t + 1 >= HLD_TIMEOUT) begin
          m_retry++;
          nst = (m_retry == MAX_RETRY) ? 6 : 1;
        end
      end
      3: if (m_t + 1 >= SAR_BITS * STEP_DIV) nst = 4;
      4: if (m_t + 1 >= SETTLE_CYC) begin nst = 5; m_retry = 0; end
      5: begin
        if ((m_t + 1) % STEP_DIV == 0) begin
          hist.push_back(int'(comp));
          if (hist.size() >= TRACK_LIMIT) begin
            same = 1;
            for (int i = 1; i < TRACK_LIMIT; i++)
              if (hist[hist.size() - 1 - i] != hist[hist.size() - 1]) same = 0;
            loss = same;
          end
        end
        if (loss) nst = 1;
      end
      6: if (!enable) nst = 0;
      default: nst = 0;
    endcase
    if (!enable && m_st != 6) nst = 0;
    if (m_st == 3 && nst == 4) m_code = int'(sar_q);
    if (loss && m_relock < 255) m_relock++;
    if (nst != m_st) begin
      m_t = 0; m_low = 0; hist.delete();
    end else m_t++;
    m_st = nst;
  endtask

  initial forever begin
    @(posedge clk_ext or posedge rst);
    model_step();
  end

  function automatic logic [31:0] model_vec();
    logic dm;
    dm = (m_st >= 1 && m_st <= 5);
    return {3'(m_st), (m_st == 0 || m_st == 1 || m_st == 6), dm, dm && (m_n != 0),
            2'(m_m), 4'(m_n), (m_st == 5), (m_st == 6), 10'(m_code), 8'(m_relock)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {state, ptc_rst, div_m, div_n, m_out, n_out, locked, fault, lock_code, relock_count};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_ext);
      #1;
      chk("model", dut_vec(), model_vec());
    end
  endtask

  initial begin
    int n;

    // Reset
    tick(3);
    rst = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ptc_rst", 32'(ptc_rst), 32'd1);
    chk("rst_outs", {div_m, div_n, locked, fault, m_out, n_out}, 32'd0);
    tick(2);

    // Normal acquisition
    cfg_m = 2'd2; cfg_n = 4'd4; sar_q = 10'h1A5; hld_reset_pd = 1'b0; enable = 1'b1;
    tick(62);
    chk("locked_at_62", 32'(locked), 32'd0);
    tick(1);
    chk("locked_at_63", 32'(locked), 32'd1);
    chk("lock_state", 32'(state), 32'd5);
    chk("lock_code", 32'(lock_code), 32'h1A5);
    chk("div_n_on", 32'(div_n), 32'd1);
    chk("cfg_latched", {m_out, n_out}, 32'h24);
    tick(40);
    chk("still_locked", 32'(locked), 32'd1);

    // Loss of lock
    sar_q = 10'h0F3;
    comp_hold = 1'b1;
    n = 0;
    while (locked !== 1'b0 && n < 60) begin tick(1); n++; end
    chk("lol_seen", 32'(locked), 32'd0);
    chk("lol_relock", 32'(relock_count), 32'd1);
    chk("lol_state", 32'(state), 32'd1);
    comp_hold = 1'b0;
    n = 0;
    while (locked !== 1'b1 && n < 120) begin tick(1); n++; end
    chk("relocked", 32'(locked), 32'd1);
    chk("relock_code", 32'(lock_code), 32'h0F3);
    tick(10);

    // Async reset while locked, checked between clock edges
    #1 rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_outs", dut_vec(), 32'h10000000);
    chk("arst_relock", 32'(relock_count), 32'd0);
    #1 rst = 1'b0;
    tick(20);
    chk("sar_run", 32'(state), 32'd3);

    // Abort mid SAR_RUN and re-enable with new configuration
    enable = 1'b0;
    tick(1);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_ctrl", {ptc_rst, div_m, div_n, locked}, 32'h8);
    cfg_m = 2'd1; cfg_n = 4'd0; enable = 1'b1;
    tick(1);
    chk("reen_cfg", {m_out, n_out}, 32'h10);
    chk("reen_div", {div_m, div_n}, 32'h2);
    cfg_m = 2'd3; cfg_n = 4'd9;
    tick(5);
    chk("cfg_ignored", {m_out, n_out}, 32'h10);
    enable = 1'b0;
    tick(2);

    // HLD timeout -> fault after three passes
    hld_reset_pd = 1'b1; enable = 1'b1;
    n = 0;
    while (fault !== 1'b1 && n < 4000) begin tick(1); n++; end
    chk("fault_cycle", 32'(n), 32'd3085);
    chk("fault_state", 32'(state), 32'd6);
    chk("fault_ctrl", {ptc_rst, div_m, div_n}, 32'h4);
    hld_reset_pd = 1'b0;
    tick(5);
    chk("fault_sticky", 32'(fault), 32'd1);
    enable = 1'b0;
    tick(1);
    chk("fault_clr_state", 32'(state), 32'd0);
    chk("fault_clr", 32'(fault), 32'd0);
    tick(2);

    // Repeated loss of lock until the counter saturates
    comp_hold = 1'b1; enable = 1'b1;
    n = 0;
    while (relock_count !== 8'd255 && n < 40000) begin tick(1); n++; end
    chk("relock_255", 32'(relock_count), 32'd255);
    tick(200);
    chk("relock_sat", 32'(relock_count), 32'd255);
    enable = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
